// File: rtl/event_buffer.sv
// Trigger event FIFO: captures ID, timestamp and comparator hits per strobe and
// serialises the oldest event as a framed byte packet for SPI readout.
module event_buffer #(
   parameter int         DEPTH      = 8,
   parameter int         ID_WIDTH   = 16,
   parameter int         TS_WIDTH   = 64,
   parameter int         N_CH       = 24,
   parameter logic [7:0] START_BYTE = 8'h7E,
   parameter logic [7:0] END_BYTE   = 8'h7D
) (
   input  logic                         sampling_clk,
   input  logic                         reset,
   input  logic                         trig_strobe,
   input  logic [ID_WIDTH-1:0]          trig_id,
   input  logic [TS_WIDTH-1:0]          timestamp,
   input  logic [N_CH-1:0]              c_hits,
   output logic [7:0]                   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         interrupt,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PKT_BYTES = 3 + (ID_WIDTH + TS_WIDTH + N_CH) / 8;
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int LVL_W     = $clog2(DEPTH + 1);
   localparam int IDX_W     = $clog2(PKT_BYTES);
   localparam int SH_W      = PKT_BYTES * 8;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [TS_WIDTH-1:0] ts;
      logic [N_CH-1:0]     hits;
      logic [7:0]          status;
   } evt_t;

   typedef enum logic {IDLE, SEND} state_t;

   evt_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [6:0]       drop_cnt;
   logic [SH_W-1:0]  shreg;
   logic [IDX_W-1:0] idx;
   state_t           state, state_nxt;
   logic             wr_en, pop, load, shift;
   logic [LVL_W-1:0] level_nxt;
   evt_t             wr_evt;

   assign out_valid = (state == SEND);
   assign out_last  = out_valid && (idx == IDX_W'(PKT_BYTES - 1));
   assign out_data  = shreg[SH_W-1 -: 8];

   // Fullness is judged on the registered level, so a strobe racing the final pop still drops.
   assign wr_en     = trig_strobe && (level != LVL_W'(DEPTH));
   assign level_nxt = level + LVL_W'(wr_en) - LVL_W'(pop);

   always_comb begin
      wr_evt.id     = trig_id;
      wr_evt.ts     = timestamp;
      wr_evt.hits   = c_hits;
      wr_evt.status = {(level_nxt == LVL_W'(DEPTH)), drop_cnt};
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0) begin
               load      = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               shift = 1'b1;
               if (idx == IDX_W'(PKT_BYTES - 1)) begin
                  pop       = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sampling_clk) begin
      if (!reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         drop_cnt  <= '0;
         shreg     <= '0;
         idx       <= '0;
         interrupt <= 1'b1;
      end else begin
         state     <= state_nxt;
         level     <= level_nxt;
         interrupt <= (level_nxt == '0);
         if (wr_en) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            drop_cnt <= '0;
         end else if (trig_strobe && drop_cnt != 7'h7F) begin
            drop_cnt <= drop_cnt + 7'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         // Zeros shift in behind the packet, so out_data idles at 00.
         if (load) begin
            shreg <= {START_BYTE, mem[rd_ptr], END_BYTE};
            idx   <= '0;
         end else if (shift) begin
            shreg <= {shreg[SH_W-9:0], 8'h00};
            idx   <= idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge sampling_clk) begin
      if (reset && wr_en)
         mem[wr_ptr] <= wr_evt;
   end

endmodule
